// File: rtl/ysyx_22050039_ctrl_if.sv
// Handshake and status bundle between the multi-cycle sequencer and the rest of the core.
// The master modport is the sequencer's view; the slave modport is the datapath/memory view.
interface ysyx_22050039_ctrl_if #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32
);
   logic                inst_req;
   logic                inst_valid;
   logic [INST_LEN-1:0] inst_in;
   logic [INST_LEN-1:0] inst_q;
   logic                dec_wreg;
   logic                dec_wpc;
   logic                dec_load;
   logic                dec_store;
   logic                dec_multi;
   logic                dec_ebreak;
   logic                dec_invalid;
   logic                exu_start;
   logic                exu_done;
   logic                mem_req;
   logic                mem_we;
   logic                mem_ack;
   logic                reg_wen;
   logic                pc_wen;
   logic                halt;
   logic                trap;
   logic [XLEN-1:0]     mcycle;
   logic [XLEN-1:0]     minstret;
   logic [2:0]          state;

   modport master (
      output inst_req, inst_q, exu_start, mem_req, mem_we, reg_wen, pc_wen,
             halt, trap, mcycle, minstret, state,
      input  inst_valid, inst_in, dec_wreg, dec_wpc, dec_load, dec_store,
             dec_multi, dec_ebreak, dec_invalid, exu_done, mem_ack
   );

   modport slave (
      input  inst_req, inst_q, exu_start, mem_req, mem_we, reg_wen, pc_wen,
             halt, trap, mcycle, minstret, state,
      output inst_valid, inst_in, dec_wreg, dec_wpc, dec_load, dec_store,
             dec_multi, dec_ebreak, dec_invalid, exu_done, mem_ack
   );
endinterface

// File: rtl/ysyx_22050039_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: one instruction at a time, single-shot write enables,
// cycle/instret counters, ebreak halt and invalid/timeout trap into an absorbing STOP state.
module ysyx_22050039_ctrl #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32,
   parameter int TIMEOUT  = 255
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_22050039_ctrl_if.master   bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_STOP = 3'd6
   } state_t;

   localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [XLEN-1:0] XONE      = XLEN'(1);

   state_t              state_reg;
   logic [INST_LEN-1:0] inst_q_reg;
   logic [7:0]          wait_cnt_reg;
   logic                wreg_reg, wpc_reg, ls_reg, store_reg;
   logic                inst_req_reg, exu_start_reg, mem_req_reg, mem_we_reg;
   logic                reg_wen_reg, pc_wen_reg, halt_reg, trap_reg;
   logic [XLEN-1:0]     mcycle_reg, minstret_reg;

   // Every output is a flop: request/enable levels are set when entering a state, cleared on leaving.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         inst_q_reg    <= '0;
         wait_cnt_reg  <= '0;
         wreg_reg      <= 1'b0;
         wpc_reg       <= 1'b0;
         ls_reg        <= 1'b0;
         store_reg     <= 1'b0;
         inst_req_reg  <= 1'b0;
         exu_start_reg <= 1'b0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         reg_wen_reg   <= 1'b0;
         pc_wen_reg    <= 1'b0;
         halt_reg      <= 1'b0;
         trap_reg      <= 1'b0;
         mcycle_reg    <= '0;
         minstret_reg  <= '0;
      end else begin
         mcycle_reg    <= mcycle_reg + XONE;
         exu_start_reg <= 1'b0;
         reg_wen_reg   <= 1'b0;
         pc_wen_reg    <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               state_reg    <= S_IF;
               inst_req_reg <= 1'b1;
               wait_cnt_reg <= '0;
            end
            S_IF: begin
               if (bus.inst_valid) begin
                  inst_q_reg   <= bus.inst_in;
                  inst_req_reg <= 1'b0;
                  state_reg    <= S_ID;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  inst_req_reg <= 1'b0;
                  trap_reg     <= 1'b1;
                  state_reg    <= S_STOP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            S_ID: begin
               wreg_reg  <= bus.dec_wreg;
               wpc_reg   <= bus.dec_wpc;
               ls_reg    <= bus.dec_load | bus.dec_store;
               store_reg <= bus.dec_store;
               if (bus.dec_invalid) begin
                  trap_reg  <= 1'b1;
                  state_reg <= S_STOP;
               end else if (bus.dec_ebreak) begin
                  halt_reg     <= 1'b1;
                  minstret_reg <= minstret_reg + XONE;
                  state_reg    <= S_STOP;
               end else if (bus.dec_multi) begin
                  exu_start_reg <= 1'b1;
                  wait_cnt_reg  <= '0;
                  state_reg     <= S_EX;
               end else if (bus.dec_load | bus.dec_store) begin
                  mem_req_reg  <= 1'b1;
                  mem_we_reg   <= bus.dec_store;
                  wait_cnt_reg <= '0;
                  state_reg    <= S_MEM;
               end else begin
                  reg_wen_reg <= bus.dec_wreg;
                  pc_wen_reg  <= bus.dec_wpc;
                  state_reg   <= S_WB;
               end
            end
            S_EX: begin
               if (bus.exu_done) begin
                  if (ls_reg) begin
                     mem_req_reg  <= 1'b1;
                     mem_we_reg   <= store_reg;
                     wait_cnt_reg <= '0;
                     state_reg    <= S_MEM;
                  end else begin
                     reg_wen_reg <= wreg_reg;
                     pc_wen_reg  <= wpc_reg;
                     state_reg   <= S_WB;
                  end
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  trap_reg  <= 1'b1;
                  state_reg <= S_STOP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            S_MEM: begin
               if (bus.mem_ack) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  reg_wen_reg <= wreg_reg;
                  pc_wen_reg  <= wpc_reg;
                  state_reg   <= S_WB;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  trap_reg    <= 1'b1;
                  state_reg   <= S_STOP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            S_WB: begin
               minstret_reg <= minstret_reg + XONE;
               inst_req_reg <= 1'b1;
               wait_cnt_reg <= '0;
               state_reg    <= S_IF;
            end
            default: state_reg <= S_STOP;
         endcase
      end
   end

   assign bus.inst_req  = inst_req_reg;
   assign bus.inst_q    = inst_q_reg;
   assign bus.exu_start = exu_start_reg;
   assign bus.mem_req   = mem_req_reg;
   assign bus.mem_we    = mem_we_reg;
   assign bus.reg_wen   = reg_wen_reg;
   assign bus.pc_wen    = pc_wen_reg;
   assign bus.halt      = halt_reg;
   assign bus.trap      = trap_reg;
   assign bus.mcycle    = mcycle_reg;
   assign bus.minstret  = minstret_reg;
   assign bus.state     = state_reg;
endmodule

// File: doc/ysyx_22050039_ctrl.md
Name: ysyx_22050039_ctrl

Overview:
Multi-cycle sequencer for the RV64 core. Drives fetch, decode, execute, memory and write-back in order, one instruction at a time. Gates register-file write enable and PC write enable so each fires exactly once per retired instruction. Also keeps the cycle and instret counters and handles ebreak halt, invalid-instruction trap and bus timeouts.

Parameters:
XLEN, 64, width of mcycle/minstret counters
INST_LEN, 32, instruction width
TIMEOUT, 255, max wait cycles on any handshake before trap (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  out  1  fetch request, held until inst_valid
inst_valid  in  1  fetch data valid (one-cycle pulse)
inst_in  in  INST_LEN  fetched instruction
inst_q  out  INST_LEN  latched instruction to decoder
dec_wreg  in  1  decoded: writes rd
dec_wpc  in  1  decoded: writes PC (jal/jalr/branch)
dec_load  in  1  decoded: load
dec_store  in  1  decoded: store
dec_multi  in  1  decoded: multi-cycle EX op (mul/div/rem)
dec_ebreak  in  1  decoded: ebreak
dec_invalid  in  1  decoded: invalid encoding
exu_start  out  1  one-cycle start pulse to multi-cycle unit
exu_done  in  1  multi-cycle result ready (pulse)
mem_req  out  1  data-memory request, held until mem_ack
mem_we  out  1  1 = store, valid while mem_req
mem_ack  in  1  data-memory completion (pulse)
reg_wen  out  1  GPR write enable, one cycle in WB
pc_wen  out  1  PC update enable, one cycle in WB
halt  out  1  sticky; set on ebreak
trap  out  1  sticky; set on invalid or timeout
mcycle  out  XLEN  cycles since reset
minstret  out  XLEN  retired instructions
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset, synchronous: state=IDLE (0). All outputs 0, including inst_q, counters, halt and trap. Reset overrides every event in the same cycle, mid-handshake included; pending inst_valid/mem_ack/exu_done are ignored.
- Encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, STOP=6.
- IDLE -> IF unconditionally after one cycle.
- IF: inst_req=1. On inst_valid: latch inst_in into inst_q, go to ID. Fetch latency is 0 if inst_valid arrives in the first IF cycle.
- ID: one cycle; dec_* are sampled this cycle.
  - dec_invalid -> trap=1, STOP (priority 1).
  - dec_ebreak -> halt=1, minstret+1, STOP (priority 2).
  - dec_multi -> EX, with exu_start=1 on entry (registered, exactly one cycle).
  - dec_load|dec_store -> MEM.
  - otherwise -> WB.
  - dec_* flags are latched in ID and used for the rest of the instruction.
- EX: wait for exu_done. Then go to MEM if load/store, else WB.
- MEM: mem_req=1 and mem_we=store, both held stable until mem_ack; then -> WB.
- WB: one cycle.
  - reg_wen = latched wreg, with the load path included.
  - pc_wen = latched wpc.
  - minstret += 1.
  - -> IF.
- Instructions without pc_wen need the PC incremented externally on the WB pulse. For simplicity the PC unit treats WB as an increment when pc_wen=0; the ctrl asserts nothing extra.
- Timeout: an 8-bit wait counter clears on entering IF, EX or MEM and increments each cycle spent waiting. If it reaches TIMEOUT with no handshake: trap=1, STOP, no writes.
- STOP: absorbing until rst. All request and enable outputs are 0. mcycle keeps counting.
- mcycle increments every non-reset cycle and wraps modulo 2^XLEN. minstret also wraps.
- A handshake pulse arriving in a state that does not expect it is ignored.
- reg_wen and pc_wen are never high outside WB.
- Minimum latency for a simple ALU instruction is 3 cycles (IF, ID, WB) with 0-wait fetch.

Test Plan:
- Reset, then addi with inst_valid in the first IF cycle -> states 1,2,5,1. reg_wen=1 only in WB, pc_wen=0. minstret=1 after 4 cycles from IDLE exit.
- jal with 2-cycle fetch delay -> inst_req high for 3 cycles. WB has reg_wen=1 and pc_wen=1.
- divw with exu_done 5 cycles after the start pulse -> exu_start high exactly 1 cycle. The FSM holds EX for 5 cycles, then WB.
- sd with mem_ack after 3 cycles -> mem_req=1 and mem_we=1 held for 3 cycles. WB has reg_wen=0 and pc_wen=0.
- Fetch never answers for TIMEOUT=255 cycles -> trap=1, state=6, inst_req=0. Asserting rst in the next cycle clears trap, counters and state.
- ebreak retired -> halt=1, minstret incremented, state=6 held for 100 cycles while mcycle keeps counting. A spurious mem_ack during STOP has no effect.
